// File: rtl/address_request_encoder_if.sv
// Request/grant bundle for address_request_encoder: multi-hot request side,
// binary-address valid/ready side, and status taps.
interface address_request_encoder_if #(
    parameter int P_RegWidth = 3
);
    localparam int N = 1 << P_RegWidth;

    logic [N-1:0]          In_Request;
    logic                  In_Enable;
    logic                  In_Ready;
    logic [P_RegWidth-1:0] Out_Address;
    logic                  Out_Valid;
    logic [N-1:0]          Out_Pending;
    logic                  Out_Busy;

    // Encoder side
    modport slave (
        input  In_Request, In_Enable, In_Ready,
        output Out_Address, Out_Valid, Out_Pending, Out_Busy
    );

    // Request source / address consumer side
    modport master (
        output In_Request, In_Enable, In_Ready,
        input  Out_Address, Out_Valid, Out_Pending, Out_Busy
    );
endinterface

// File: rtl/address_request_encoder.sv
// Collects multi-hot per-register requests into a pending set and issues them
// one at a time as binary addresses over valid/ready, in round-robin order.
module address_request_encoder #(
    parameter int P_RegWidth = 3
) (
    input  logic                       In_Clock,
    input  logic                       In_Reset,
    address_request_encoder_if.slave   bus
);
    localparam int N = 1 << P_RegWidth;

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          pending_q, pending_d;
    logic [P_RegWidth-1:0] rr_q, rr_d;
    logic [P_RegWidth-1:0] addr_q, addr_d;

    logic [N-1:0]          addr_oh;
    logic [N-1:0]          clr;
    logic [N-1:0]          remain;
    logic                  handshake;

    // First set bit of mask scanning upward from ptr, wrapping modulo N.
    function automatic logic [P_RegWidth-1:0] sel(input logic [N-1:0] mask,
                                                  input logic [P_RegWidth-1:0] ptr);
        logic [P_RegWidth-1:0] idx;
        logic                  hit;
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + P_RegWidth'(i);
            if (!hit && mask[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
    endfunction

    // Pending-set update: completed grant clears its bit, new requests set
    // bits, and a set in the same cycle overrides the clear.
    always_comb begin
        handshake = (state_q == OFFER) && bus.In_Ready;
        addr_oh   = {{(N-1){1'b0}}, 1'b1} << addr_q;
        clr       = handshake ? addr_oh : '0;
        remain    = pending_q & ~addr_oh;
        pending_d = (pending_q & ~clr) | (bus.In_Enable ? bus.In_Request : '0);
    end

    // Offer FSM: selection only looks at registered pending, so requests
    // captured this cycle are seen next cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    addr_d  = sel(pending_q, rr_q);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.In_Ready) begin
                    rr_d = addr_q + 1'b1;
                    if (remain != '0) begin
                        addr_d = sel(remain, addr_q + 1'b1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight offer.
    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_q      <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.Out_Address = addr_q;
    assign bus.Out_Valid   = (state_q == OFFER);
    assign bus.Out_Pending = pending_q;
    assign bus.Out_Busy    = (pending_q != '0) || (state_q == OFFER);

endmodule

// File: tb/tb_address_request_encoder.sv
// Scoreboard bench for address_request_encoder: expected grant addresses are
// queued as requests are driven and popped at each completed handshake.
module tb_address_request_encoder;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [2:0] exp_q[$];

    address_request_encoder_if #(.P_RegWidth(3)) bus();

    address_request_encoder #(.P_RegWidth(3)) dut (
        .In_Clock (clk),
        .In_Reset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.In_Request = 8'h00;
        bus.In_Enable  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.In_Ready = 1'b1;
        #12;
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Address !== 3'd0 ||
            bus.Out_Pending !== 8'h00 || bus.Out_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b addr=%0d pend=%h busy=%b, want 0/0/00/0",
                     bus.Out_Valid, bus.Out_Address, bus.Out_Pending, bus.Out_Busy);
        end
        @(negedge clk);
        rst = 1'b0;
        // load A5 with the consumer stalled so the encoder sits in OFFER
        @(negedge clk);
        bus.In_Ready = 1'b0;
        bus.In_Request = 8'hA5; bus.In_Enable = 1'b1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.Out_Valid !== 1'b1 || bus.Out_Pending !== 8'hA5) begin
            errors++;
            $display("FAIL reset_preload: valid=%b pend=%h, want 1/a5", bus.Out_Valid, bus.Out_Pending);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Address !== 3'd0 ||
            bus.Out_Pending !== 8'h00 || bus.Out_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_offer: valid=%b addr=%0d pend=%h busy=%b, want 0/0/00/0",
                     bus.Out_Valid, bus.Out_Address, bus.Out_Pending, bus.Out_Busy);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.In_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.Out_Valid !== 1'b0 || bus.Out_Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_quiet: valid=%b busy=%b, want 0/0", bus.Out_Valid, bus.Out_Busy);
            end
        end
    endtask

    task automatic test_single();
        int cyc;
        int first;
        logic [2:0] want;
        exp_q.push_back(3'd5);
        @(negedge clk);
        bus.In_Ready = 1'b1;
        bus.In_Request = 8'h20; bus.In_Enable = 1'b1;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.Out_Pending !== 8'h20 || bus.Out_Valid !== 1'b0 || bus.Out_Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_capture: pend=%h valid=%b busy=%b, want 20/0/1",
                     bus.Out_Pending, bus.Out_Valid, bus.Out_Busy);
        end
        cyc = 0; first = -1;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (bus.Out_Valid && bus.In_Ready) begin
                want = exp_q.pop_front();
                if (first < 0) first = cyc;
                checks++;
                if (bus.Out_Address !== want) begin
                    errors++;
                    $display("FAIL single_addr: got %0d want %0d", bus.Out_Address, want);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || first != 1) begin
            errors++;
            $display("FAIL single_latency: first grant cycle %0d left %0d, want 1/0", first, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Pending !== 8'h00 || bus.Out_Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: valid=%b pend=%h busy=%b, want 0/00/0",
                     bus.Out_Valid, bus.Out_Pending, bus.Out_Busy);
        end
    endtask

    // Runs right after test_single, so the pointer sits at 6.
    task automatic test_rr_wrap();
        int cyc;
        logic [2:0] want;
        exp_q.push_back(3'd6); exp_q.push_back(3'd0); exp_q.push_back(3'd5);
        @(negedge clk);
        bus.In_Request = 8'h61; bus.In_Enable = 1'b1;
        @(negedge clk);
        idle_inputs();
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (bus.Out_Valid && bus.In_Ready) begin
                want = exp_q.pop_front();
                checks++;
                if (bus.Out_Address !== want) begin
                    errors++;
                    $display("FAIL rr_wrap_addr: got %0d want %0d", bus.Out_Address, want);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_wrap_timeout: %0d grants missing, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int first;
        int last;
        logic [2:0] want;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd7);
        @(negedge clk);
        bus.In_Request = 8'h85; bus.In_Enable = 1'b1;
        @(negedge clk);
        idle_inputs();
        cyc = 0; first = -1; last = -1;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (bus.Out_Valid && bus.In_Ready) begin
                want = exp_q.pop_front();
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (bus.Out_Address !== want) begin
                    errors++;
                    $display("FAIL burst_addr: got %0d want %0d", bus.Out_Address, want);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || first != 1 || last != 3) begin
            errors++;
            $display("FAIL burst_timing: grants at cycles %0d..%0d left %0d, want 1..3/0", first, last, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_done: valid=%b busy=%b, want 0/0", bus.Out_Valid, bus.Out_Busy);
        end
    endtask

    // Pointer is 0 after the burst (last grant 7 wraps it).
    task automatic test_stall_set_wins();
        int cyc;
        logic [2:0] want;
        exp_q.push_back(3'd3); exp_q.push_back(3'd0); exp_q.push_back(3'd3);
        @(negedge clk);
        bus.In_Ready = 1'b0;
        bus.In_Request = 8'h08; bus.In_Enable = 1'b1;
        @(negedge clk);
        bus.In_Request = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.Out_Valid !== 1'b1 || bus.Out_Address !== 3'd3) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b addr=%0d, want 1/3", i, bus.Out_Valid, bus.Out_Address);
            end
        end
        // handshake cycle re-requests bit 3
        bus.In_Ready = 1'b1;
        bus.In_Request = 8'h08; bus.In_Enable = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            if (bus.Out_Valid && bus.In_Ready) begin
                want = exp_q.pop_front();
                checks++;
                if (bus.Out_Address !== want) begin
                    errors++;
                    $display("FAIL stall_order: got %0d want %0d", bus.Out_Address, want);
                end
            end
            @(negedge clk); cyc++;
            idle_inputs();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_timeout: %0d grants missing, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Pending !== 8'h00) begin
            errors++;
            $display("FAIL stall_done: valid=%b pend=%h, want 0/00", bus.Out_Valid, bus.Out_Pending);
        end
    endtask

    task automatic test_enable_gating();
        @(negedge clk);
        bus.In_Ready = 1'b1;
        bus.In_Request = 8'hFF; bus.In_Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.Out_Pending !== 8'h00 || bus.Out_Valid !== 1'b0 || bus.Out_Busy !== 1'b0) begin
                errors++;
                $display("FAIL enable_gating: cycle %0d pend=%h valid=%b busy=%b, want 00/0/0",
                         i, bus.Out_Pending, bus.Out_Valid, bus.Out_Busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_rr_wrap();
        test_back_to_back();
        test_stall_set_wins();
        test_enable_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
